// File: rtl/shift_scheduler_pkg.sv
// rtl/shift_scheduler_pkg.sv - shared state encoding and default sizes for the shift scheduler
package shift_scheduler_pkg;

    localparam int DEFAULT_WIDTH   = 12;
    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/shift_scheduler_rr_arbiter.sv
// rtl/shift_scheduler_rr_arbiter.sv - combinational round-robin pick of the first requester after i_last
module rr_arbiter
    import shift_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int LANE_W  = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [LANE_W-1:0]  i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [LANE_W-1:0]  o_idx
);

    logic              w_found;
    logic [LANE_W-1:0] w_cand;

    // Walk lanes last+1, last+2, ... wrapping, so last itself is checked at the very end.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = LANE_W'((int'(i_last) + i) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/shift_scheduler.sv
// rtl/shift_scheduler.sv - round-robin sharing of one load/shift serializer among lanes, one job per tick
// Optional overrun counter enabled by SHIFT_SCHED_STATS_EN.
module shift_scheduler
    import shift_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LANE_W  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   pattern,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       sr_enable,
    output logic [WIDTH-1:0]           sr_d,
    input  logic                       sr_q,
    output logic                       bit_out,
    output logic                       bit_valid,
    output logic [3:0]                 bit_idx,
    output logic [LANE_W-1:0]          bit_lane,
    output logic                       busy
`ifdef SHIFT_SCHED_STATS_EN
    ,
    output logic [7:0]                 overrun
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

    sched_state_t       r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [LANE_W-1:0]  r_lane, w_lane_nxt;
    logic [LANE_W-1:0]  r_last, w_last_nxt;
    logic [WIDTH-1:0]   r_pattern, w_pattern_nxt;
    logic [3:0]         r_bit_idx, w_bit_idx_nxt;

    logic [NUM_REQ-1:0] w_win_onehot;
    logic [LANE_W-1:0]  w_win_idx;
    logic [WIDTH-1:0]   w_pat [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_pat[g] = pattern[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .LANE_W  (LANE_W)
    ) u_arb (
        .i_req   (req),
        .i_last  (r_last),
        .o_grant (w_win_onehot),
        .o_idx   (w_win_idx)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant   <= '0;
            r_lane    <= '0;
            r_last    <= LANE_W'(NUM_REQ - 1);
            r_pattern <= '0;
            r_bit_idx <= '0;
        end else begin
            r_grant   <= w_grant_nxt;
            r_lane    <= w_lane_nxt;
            r_last    <= w_last_nxt;
            r_pattern <= w_pattern_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_lane_nxt    = r_lane;
        w_last_nxt    = r_last;
        w_pattern_nxt = r_pattern;
        w_bit_idx_nxt = r_bit_idx;
        sr_enable     = 1'b1;
        sr_d          = '0;
        bit_valid     = 1'b0;
        ack           = '0;
        case (r_state)
            IDLE: begin
                // A tick with no requester is simply consumed.
                if (tick && |req) begin
                    w_state_nxt   = LOAD;
                    w_grant_nxt   = w_win_onehot;
                    w_lane_nxt    = w_win_idx;
                    w_pattern_nxt = w_pat[w_win_idx];
                end
            end
            LOAD: begin
                sr_enable     = 1'b0;
                sr_d          = r_pattern;
                w_state_nxt   = SHIFT;
                w_bit_idx_nxt = '0;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                if (r_bit_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_bit_idx_nxt = r_bit_idx + 4'd1;
                end
            end
            DONE: begin
                ack           = r_grant;
                w_last_nxt    = r_lane;
                w_state_nxt   = IDLE;
                w_grant_nxt   = '0;
                w_lane_nxt    = '0;
                w_bit_idx_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign grant    = r_grant;
    assign bit_idx  = r_bit_idx;
    assign bit_lane = r_lane;
    assign busy     = (r_state != IDLE);
    assign bit_out  = bit_valid & sr_q;

`ifdef SHIFT_SCHED_STATS_EN
    logic [7:0] r_overrun;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overrun <= '0;
        end else if (tick && (r_state != IDLE) && (r_overrun != 8'hFF)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_shift_scheduler.sv
// tb/tb_shift_scheduler.sv - directed and randomized bench for shift_scheduler with a 12-bit shift register model
module tb_shift_scheduler;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int LW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           tick = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] pattern = '0;
    logic [N-1:0]   grant, ack;
    logic           sr_enable;
    logic [W-1:0]   sr_d;
    logic           sr_q, bit_out, bit_valid, busy;
    logic [3:0]     bit_idx;
    logic [LW-1:0]  bit_lane;
`ifdef SHIFT_SCHED_STATS_EN
    logic [7:0]     overrun;
`endif

    logic [W-1:0]   sr_reg = '0;
    int             checks = 0;
    int             failures = 0;
    int             m_last = N - 1;
    int             m_overrun = 0;

    shift_scheduler #(.NUM_REQ(N), .WIDTH(W), .LANE_W(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .req       (req),
        .pattern   (pattern),
        .grant     (grant),
        .ack       (ack),
        .sr_enable (sr_enable),
        .sr_d      (sr_d),
        .sr_q      (sr_q),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_idx   (bit_idx),
        .bit_lane  (bit_lane),
        .busy      (busy)
`ifdef SHIFT_SCHED_STATS_EN
        ,
        .overrun   (overrun)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!sr_enable) sr_reg <= sr_d;
        else            sr_reg <= {sr_reg[W-2:0], 1'b0};
    end
    assign sr_q = sr_reg[W-1];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_overrun();
`ifdef SHIFT_SCHED_STATS_EN
        chk("overrun", 32'(overrun), (m_overrun > 255) ? 255 : m_overrun);
`endif
    endtask

    task automatic run_job(input logic [N-1:0] rq, input int tick_k, input bit tick_done, input bit mutate);
        int           lane;
        logic [W-1:0] exp_pat;
        logic [N-1:0] oh;
        req     = rq;
        lane    = pick(rq, m_last);
        exp_pat = pattern[lane*W +: W];
        oh      = 4'b0001 << lane;
        tick    = 1'b1;
        step();
        tick    = 1'b0;
        chk("load_grant", 32'(grant), 32'(oh));
        chk("load_en", 32'(sr_enable), 0);
        chk("load_d", 32'(sr_d), 32'(exp_pat));
        chk("load_lane", 32'(bit_lane), lane);
        chk("load_busy", 32'(busy), 1);
        chk("load_valid", 32'(bit_valid), 0);
        if (mutate) begin
            req[lane] = 1'b0;
            pattern[lane*W +: W] = ~exp_pat;
        end
        for (int k = 0; k < W; k++) begin
            step();
            tick = 1'b0;
            chk("sh_valid", 32'(bit_valid), 1);
            chk("sh_idx", 32'(bit_idx), k);
            chk("sh_bit", 32'(bit_out), 32'(exp_pat[W-1-k]));
            chk("sh_grant", 32'(grant), 32'(oh));
            chk("sh_en_d", {19'd0, sr_enable, sr_d}, {19'd0, 1'b1, 12'd0});
            chk("sh_ack", 32'(ack), 0);
            if (k == tick_k) begin
                tick = 1'b1;
                m_overrun++;
            end
        end
        step();
        tick = 1'b0;
        chk("done_ack", 32'(ack), 32'(oh));
        chk("done_grant", 32'(grant), 32'(oh));
        chk("done_busy", 32'(busy), 1);
        chk("done_valid", 32'(bit_valid), 0);
        if (tick_done) begin
            tick = 1'b1;
            m_overrun++;
        end
        m_last = lane;
        step();
        tick = 1'b0;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_grant", 32'(grant), 0);
        chk("idle_ack", 32'(ack), 0);
        chk("idle_lane", 32'(bit_lane), 0);
        chk_overrun();
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("gap_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        step();
        step();
        chk("rst_grant_ack", {grant, ack}, 0);
        chk("rst_sr", {19'd0, sr_enable, sr_d}, {19'd0, 1'b1, 12'd0});
        chk("rst_bit", {bit_valid, bit_out, bit_idx, bit_lane}, 0);
        chk("rst_busy", 32'(busy), 0);
        chk_overrun();
        reset = 1'b1;
        step();

        // 1: single lane, known pattern
        pattern[0*W +: W] = 12'hA5C;
        run_job(4'b0001, -1, 1'b0, 1'b0);
        gap(2);

        // 2: all lanes requesting rotate through every lane
        for (int j = 0; j < 5; j++) begin
            for (int l = 0; l < N; l++) pattern[l*W +: W] = 12'($urandom);
            run_job(4'b1111, -1, 1'b0, 1'b0);
            gap(5);
        end

        // 3: two sparse requesters alternate
        for (int j = 0; j < 3; j++) begin
            run_job(4'b0101, -1, 1'b0, 1'b0);
            gap(5);
        end

        // 4: ticks during a job are ignored and counted
        m_overrun = 0;
        run_job(4'b0001, 3, 1'b1, 1'b0);
        gap(1);

        // 5: request dropped and pattern changed mid-job
        pattern[2*W +: W] = 12'h3C6;
        run_job(4'b0100, -1, 1'b0, 1'b1);
        gap(1);

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            logic [N-1:0] rq;
            for (int l = 0; l < N; l++) pattern[l*W +: W] = 12'($urandom);
            gap($urandom_range(0, 3));
            rq = 4'($urandom_range(0, 15));
            if (rq == 0) begin
                req  = rq;
                tick = 1'b1;
                step();
                tick = 1'b0;
                chk("notick_busy", 32'(busy), 0);
                chk("notick_grant", 32'(grant), 0);
            end else begin
                run_job(rq, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W-1)) : -1,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

`ifdef SHIFT_SCHED_STATS_EN
        req  = 4'b1111;
        tick = 1'b1;
        for (int i = 0; i < 400; i++) step();
        tick = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_busy", 32'(busy), 0);
        m_overrun = 255;
        chk_overrun();
`endif

        // 6: reset mid-job
        req  = 4'b1111;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k <= 5; k++) step();
        chk("pre_rst_idx", 32'(bit_idx), 5);
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_valid", 32'(bit_valid), 0);
        chk("mid_rst_en", 32'(sr_enable), 1);
        chk("mid_rst_busy_ack", {busy, ack}, 0);
        m_last    = N - 1;
        m_overrun = 0;
        chk_overrun();
        step();
        reset = 1'b1;
        step();
        run_job(4'b1111, -1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_scheduler.md
Name: shift_scheduler

Overview:
- Shares the single 12-bit load/shift serializer among NUM_REQ requesting lanes (lava rows) using round-robin arbitration.
- Starts at most one job per screen-roll tick. For each job it loads the winning lane's pattern, steps the register through WIDTH shift cycles and presents the serial bits to the display path.
- Sits between the lane pattern generators, the rate-divider tick and the external shift register.

Parameters:
- NUM_REQ, 4, number of requesting lanes (2..8).
- WIDTH, 12, pattern width; must equal the shift register width.
- LANE_W, 2, lane index width; equals clog2(NUM_REQ).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle pulse from the rate divider; the only event that can start a job.
- req  in  NUM_REQ  level request per lane.
- pattern  in  NUM_REQ*WIDTH  lane i pattern at bits [i*WIDTH +: WIDTH].
- grant  out  NUM_REQ  one-hot; marks the lane owning the current job.
- ack  out  NUM_REQ  one-cycle pulse on the owning lane when its job completes.
- sr_enable  out  1  to the shift register: 0 = load, 1 = shift.
- sr_d  out  WIDTH  parallel load data to the shift register.
- sr_q  in  1  serial MSB from the shift register.
- bit_out  out  1  serial pixel bit; equals sr_q when bit_valid, else 0.
- bit_valid  out  1  high during the WIDTH shift cycles.
- bit_idx  out  4  index of the current bit: 0 = pattern MSB.
- bit_lane  out  LANE_W  lane index of the current job.
- busy  out  1  high in every state except IDLE.
- `ifdef SHIFT_SCHED_STATS_EN: overrun  out  8  saturating count of ignored ticks.

Behaviour:
- Reset values (asynchronous, active-low):
  - state=IDLE, grant=0, ack=0.
  - sr_enable=1, sr_d=0.
  - bit_valid=0, bit_idx=0, bit_lane=0, busy=0.
  - Round-robin pointer last=NUM_REQ-1, so lane 0 has first priority.
  - overrun=0.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If tick && |req: pick the first requesting lane after `last`, cyclically.
  - Set grant one-hot, capture that lane's pattern into an internal register, set bit_lane, go to LOAD.
  - If tick && ~|req: stay in IDLE; the tick is consumed and not counted.
- LOAD (exactly 1 cycle): sr_enable=0, sr_d=captured pattern. The register loads on the closing edge. Go to SHIFT with bit_idx=0.
- SHIFT (exactly WIDTH cycles):
  - sr_enable=1, bit_valid=1, bit_out=sr_q.
  - In cycle k, bit_out equals pattern[WIDTH-1-k]; bit_idx=k.
  - After bit_idx=WIDTH-1, go to DONE.
- DONE (1 cycle):
  - ack[lane]=1, grant stays set, last=lane.
  - Next state is IDLE; grant and bit_lane clear on entry to IDLE.
- Latency: tick to first valid bit is 2 cycles (IDLE→LOAD→SHIFT). A job occupies WIDTH+2 busy cycles.
- Outside LOAD, sr_d holds 0 and sr_enable holds 1.
- Request dropped after grant: the job completes normally with the captured pattern, and ack is still pulsed.
- Pattern changed mid-job: no effect on the job; the captured copy is used.
- Tick in LOAD, SHIFT or DONE: ignored; no job is queued.
- Single requester: the same lane is granted on consecutive ticks. The pointer only skips lanes that are not requesting.
- Reset asserted mid-job: all outputs go to reset values immediately, no ack is issued, and the pointer returns to its reset value.

Optional Feature:
- SHIFT_SCHED_STATS_EN defined:
  - The overrun port exists.
  - It increments on every tick seen in LOAD, SHIFT or DONE, saturating at 255.
  - It clears only on reset.
- Not defined: no port, no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package:
  - state encoding typedef: IDLE=0, LOAD=1, SHIFT=2, DONE=3.
  - constants DEFAULT_WIDTH=12 and DEFAULT_NUM_REQ=4.
- One natural sub-module, rr_arbiter (combinational): takes req and last, returns the one-hot winner and its index. It is instantiated once.

Test Plan:
All scenarios use NUM_REQ=4, WIDTH=12, with the team's 12-bit shift register model attached.
1. req=0001, pattern0=12'hA5C, tick: LOAD cycle has sr_enable=0, sr_d=A5C. Then 12 bit_valid cycles carry 1,0,1,0,0,1,0,1,1,1,0,0. Then ack=0001 for 1 cycle, then busy=0.
2. req=1111 held, 5 ticks spaced 20 cycles apart: grants are 0001, 0010, 0100, 1000, 0001.
3. req=0101, ticks spaced 20 cycles apart: grants alternate 0001, 0100, 0001.
4. Tick at SHIFT bit_idx=3 and in the DONE cycle: no extra job starts. With SHIFT_SCHED_STATS_EN, overrun=2. Force 300 overruns: overrun=255.
5. Drop req[2] one cycle after grant=0100, change pattern2 mid-job: the original bits stream out and ack=0100 still pulses.
6. Reset low at SHIFT bit_idx=5: in the same cycle grant=0, bit_valid=0, sr_enable=1. After release, req=1111 + tick grants 0001.
